cv32e40p_apu_arbiter: RTL and testbench

- Shares one APU/FPU between NUM_CORES cv32e40p cores in a PULP cluster.
- Each core's APU request channel is arbitrated round-robin onto the single shared APU port.
- Responses return in issue order and are routed back through an in-order ID FIFO.
- Sits between the cores' apu_* ports and the shared FPU instance.

---
 rtl/cv32e40p_apu_arb_pkg.sv | 34 +++
 rtl/cv32e40p_apu_core_pkg.sv | 7 +
 rtl/cv32e40p_apu_id_fifo.sv | 49 ++++
 rtl/cv32e40p_apu_arbiter.sv | 139 +++++++++++++
 tb/tb_cv32e40p_apu_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40p_apu_arb_pkg.sv
// Types and the round-robin pick function used by the shared-APU arbiter.
package cv32e40p_apu_arb_pkg;
  import cv32e40p_apu_core_pkg::*;

  localparam int MAX_CORES = 16;
  localparam int MAX_ID_W  = 4;

  typedef struct packed {
    logic [APU_NARGS_CPU-1:0][31:0]  operands;
    logic [APU_WOP_CPU-1:0]          op;
    logic [APU_NDSFLAGS_CPU-1:0]     flags;
  } apu_req_payload_t;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  // First requester at or after ptr, wrapping at num; returns ptr when nobody requests.
  function automatic int rr_pick(input logic [MAX_CORES-1:0] req,
                                 input logic [MAX_ID_W-1:0]  ptr,
                                 input int                   num);
    int win;
    int idx;
    win = int'(ptr);
    for (int k = MAX_CORES - 1; k >= 0; k--) begin
      if (k < num) begin
        idx = (int'(ptr) + k) % num;
        if (req[idx[MAX_ID_W-1:0]]) win = idx;
      end
    end
    return win;
  endfunction
endpackage

// File: rtl/cv32e40p_apu_core_pkg.sv
// APU interface widths shared by every cv32e40p core and the cluster FPU.
package cv32e40p_apu_core_pkg;
  localparam int APU_NARGS_CPU    = 3;
  localparam int APU_WOP_CPU      = 6;
  localparam int APU_NDSFLAGS_CPU = 15;
  localparam int APU_NUSFLAGS_CPU = 5;
endpackage

// File: rtl/cv32e40p_apu_id_fifo.sv
// In-order FIFO of core indices for operations issued to the shared APU.
module cv32e40p_apu_id_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  logic [W-1:0]  data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one APU/FPU between cv32e40p cores; responses
// are steered back in issue order through an ID FIFO.
module cv32e40p_apu_arbiter
  import cv32e40p_apu_core_pkg::*;
  import cv32e40p_apu_arb_pkg::*;
#(
  parameter int NUM_CORES     = 4,
  parameter int ID_FIFO_DEPTH = 4,
  parameter int ID_W          = $clog2(NUM_CORES)
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic [NUM_CORES-1:0]                           core_apu_req_i,
  output logic [NUM_CORES-1:0]                           core_apu_gnt_o,
  input  logic [NUM_CORES-1:0][APU_NARGS_CPU-1:0][31:0]  core_apu_operands_i,
  input  logic [NUM_CORES-1:0][APU_WOP_CPU-1:0]          core_apu_op_i,
  input  logic [NUM_CORES-1:0][APU_NDSFLAGS_CPU-1:0]     core_apu_flags_i,
  output logic [NUM_CORES-1:0]                           core_apu_rvalid_o,
  output logic [31:0]                                    core_apu_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]                    core_apu_flags_o,
  output logic                                           apu_req_o,
  input  logic                                           apu_gnt_i,
  output logic [APU_NARGS_CPU-1:0][31:0]                 apu_operands_o,
  output logic [APU_WOP_CPU-1:0]                         apu_op_o,
  output logic [APU_NDSFLAGS_CPU-1:0]                    apu_flags_o,
  input  logic                                           apu_rvalid_i,
  input  logic [31:0]                                    apu_result_i,
  input  logic [APU_NUSFLAGS_CPU-1:0]                    apu_flags_i,
  output logic [$clog2(ID_FIFO_DEPTH):0]                 outstanding_o,
  output logic                                           err_o
);
  // Handshakes: a core holds req and payload until it sees gnt; a transfer
  // happens in the cycle where apu_req_o and apu_gnt_i are both high, and
  // core_apu_gnt_o mirrors that cycle for the selected core only.

  typedef struct packed {
    lock_state_e     lock_st;
    logic [ID_W-1:0] lock_idx;
    logic [ID_W-1:0] rr_ptr;
  } arb_state_t;

  arb_state_t           st_q;
  logic [MAX_CORES-1:0] req_ext;
  logic [ID_W-1:0]      winner;
  logic [ID_W-1:0]      head_id;
  logic                 locked;
  logic                 sel_valid;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 handshake;
  logic                 pop;
  logic                 lock_violation;
  logic                 spurious_rvalid;
  apu_req_payload_t     payload;

  always_comb begin
    req_ext                 = '0;
    req_ext[NUM_CORES-1:0]  = core_apu_req_i;
  end

  assign locked    = (st_q.lock_st == LOCK_HELD);
  assign winner    = locked ? st_q.lock_idx
                            : ID_W'(rr_pick(req_ext, MAX_ID_W'(st_q.rr_ptr), NUM_CORES));
  assign sel_valid = locked || (|core_apu_req_i);
  // Full blocks issue outright, so a same-cycle rvalid never feeds back into req.
  assign apu_req_o = sel_valid && !fifo_full;
  assign handshake = apu_req_o && apu_gnt_i;
  assign pop       = apu_rvalid_i && !fifo_empty;

  assign spurious_rvalid = apu_rvalid_i && fifo_empty;
  assign lock_violation  = locked && !core_apu_req_i[st_q.lock_idx];

  always_comb begin
    payload = '0;
    if (sel_valid) begin
      payload.operands = core_apu_operands_i[winner];
      payload.op       = core_apu_op_i[winner];
      payload.flags    = core_apu_flags_i[winner];
    end
  end

  assign apu_operands_o = payload.operands;
  assign apu_op_o       = payload.op;
  assign apu_flags_o    = payload.flags;

  always_comb begin
    core_apu_gnt_o         = '0;
    core_apu_gnt_o[winner] = handshake;
  end

  always_comb begin
    core_apu_rvalid_o          = '0;
    core_apu_rvalid_o[head_id] = pop;
  end

  assign core_apu_result_o = apu_result_i;
  assign core_apu_flags_o  = apu_flags_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q.lock_st  <= LOCK_IDLE;
      st_q.lock_idx <= '0;
      st_q.rr_ptr   <= '0;
      err_o         <= 1'b0;
    end else begin
      if (handshake) begin
        st_q.rr_ptr <= (winner == ID_W'(NUM_CORES - 1)) ? '0 : winner + 1'b1;
      end
      case (st_q.lock_st)
        LOCK_IDLE: begin
          if (apu_req_o && !apu_gnt_i) begin
            st_q.lock_st  <= LOCK_HELD;
            st_q.lock_idx <= winner;
          end
        end
        LOCK_HELD: begin
          if (apu_gnt_i) st_q.lock_st <= LOCK_IDLE;
        end
        default: st_q.lock_st <= LOCK_IDLE;
      endcase
      if (spurious_rvalid || lock_violation) err_o <= 1'b1;
    end
  end

  cv32e40p_apu_id_fifo #(
    .DEPTH (ID_FIFO_DEPTH),
    .W     (ID_W)
  ) u_id_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (handshake),
    .data  (winner),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding_o),
    .head  (head_id)
  );
endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Bench for the shared-APU arbiter: directed scenarios with literal expectations
// plus randomized OBI traffic checked every cycle against a queue-based model.
module tb_cv32e40p_apu_arbiter;
  import cv32e40p_apu_core_pkg::*;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]                           core_apu_req_i = '0;
  logic [N-1:0]                           core_apu_gnt_o;
  logic [N-1:0][APU_NARGS_CPU-1:0][31:0]  core_apu_operands_i = '0;
  logic [N-1:0][APU_WOP_CPU-1:0]          core_apu_op_i = '0;
  logic [N-1:0][APU_NDSFLAGS_CPU-1:0]     core_apu_flags_i = '0;
  logic [N-1:0]                           core_apu_rvalid_o;
  logic [31:0]                            core_apu_result_o;
  logic [APU_NUSFLAGS_CPU-1:0]            core_apu_flags_o;
  logic                                   apu_req_o;
  logic                                   apu_gnt_i = 1'b0;
  logic [APU_NARGS_CPU-1:0][31:0]         apu_operands_o;
  logic [APU_WOP_CPU-1:0]                 apu_op_o;
  logic [APU_NDSFLAGS_CPU-1:0]            apu_flags_o;
  logic                                   apu_rvalid_i = 1'b0;
  logic [31:0]                            apu_result_i = '0;
  logic [APU_NUSFLAGS_CPU-1:0]            apu_flags_i = '0;
  logic [CW-1:0]                          outstanding_o;
  logic                                   err_o;

  cv32e40p_apu_arbiter #(
    .NUM_CORES     (N),
    .ID_FIFO_DEPTH (D)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .core_apu_req_i      (core_apu_req_i),
    .core_apu_gnt_o      (core_apu_gnt_o),
    .core_apu_operands_i (core_apu_operands_i),
    .core_apu_op_i       (core_apu_op_i),
    .core_apu_flags_i    (core_apu_flags_i),
    .core_apu_rvalid_o   (core_apu_rvalid_o),
    .core_apu_result_o   (core_apu_result_o),
    .core_apu_flags_o    (core_apu_flags_o),
    .apu_req_o           (apu_req_o),
    .apu_gnt_i           (apu_gnt_i),
    .apu_operands_o      (apu_operands_o),
    .apu_op_o            (apu_op_o),
    .apu_flags_o         (apu_flags_o),
    .apu_rvalid_i        (apu_rvalid_i),
    .apu_result_i        (apu_result_i),
    .apu_flags_i         (apu_flags_i),
    .outstanding_o       (outstanding_o),
    .err_o               (err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: expected queue of in-flight core ids plus arbitration state
  logic [1:0]   exp_q[$];
  int           m_rr    = 0;
  bit           m_lock  = 1'b0;
  int           m_lk    = 0;
  bit           m_err   = 1'b0;
  bit           m_valid = 1'b0;
  logic [N-1:0] m_gnt_last = '0;

  always @(negedge clk) begin
    int                              win;
    bit                              found;
    bit                              sel;
    bit                              e_req;
    bit                              hs;
    bit                              pop;
    logic [N-1:0]                    e_gnt;
    logic [N-1:0]                    e_rv;
    logic [APU_NARGS_CPU-1:0][31:0]  e_opnd;
    logic [APU_WOP_CPU-1:0]          e_op;
    logic [APU_NDSFLAGS_CPU-1:0]     e_fl;
    win   = m_lk;
    found = 1'b0;
    if (!m_lock) begin
      for (int k = 0; k < N; k++) begin
        if (!found && core_apu_req_i[(m_rr + k) % N]) begin
          win   = (m_rr + k) % N;
          found = 1'b1;
        end
      end
    end
    sel    = m_lock || found;
    e_req  = sel && (exp_q.size() < D);
    hs     = e_req && apu_gnt_i;
    pop    = apu_rvalid_i && (exp_q.size() != 0);
    e_gnt  = hs ? (N'(1) << win) : '0;
    e_rv   = pop ? (N'(1) << exp_q[0]) : '0;
    e_opnd = sel ? core_apu_operands_i[win] : '0;
    e_op   = sel ? core_apu_op_i[win] : '0;
    e_fl   = sel ? core_apu_flags_i[win] : '0;
    if (m_valid) begin
      check("m_apu_req",  128'(apu_req_o),          128'(e_req));
      check("m_gnt",      128'(core_apu_gnt_o),     128'(e_gnt));
      check("m_rvalid",   128'(core_apu_rvalid_o),  128'(e_rv));
      check("m_operands", 128'(apu_operands_o),     128'(e_opnd));
      check("m_op",       128'(apu_op_o),           128'(e_op));
      check("m_dflags",   128'(apu_flags_o),        128'(e_fl));
      check("m_result",   128'(core_apu_result_o),  128'(apu_result_i));
      check("m_uflags",   128'(core_apu_flags_o),   128'(apu_flags_i));
      check("m_outst",    128'(outstanding_o),      128'(exp_q.size()));
      check("m_err",      128'(err_o),              128'(m_err));
    end
    m_gnt_last = e_gnt;
    if (rst_i) begin
      exp_q.delete();
      m_rr    = 0;
      m_lock  = 1'b0;
      m_lk    = 0;
      m_err   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if ((apu_rvalid_i && exp_q.size() == 0) || (m_lock && !core_apu_req_i[m_lk])) m_err = 1'b1;
      if (pop) void'(exp_q.pop_front());
      if (hs) begin
        exp_q.push_back(2'(win));
        m_rr = (win + 1) % N;
      end
      if (!m_lock && e_req && !apu_gnt_i) begin
        m_lock = 1'b1;
        m_lk   = win;
      end else if (m_lock && apu_gnt_i) begin
        m_lock = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_payload(input int c, input logic [APU_WOP_CPU-1:0] op);
    core_apu_op_i[c]    = op;
    core_apu_flags_i[c] = APU_NDSFLAGS_CPU'($urandom);
    for (int a = 0; a < APU_NARGS_CPU; a++) core_apu_operands_i[c][a] = $urandom;
  endtask

  task automatic idle_inputs();
    core_apu_req_i = '0;
    apu_gnt_i      = 1'b0;
    apu_rvalid_i   = 1'b0;
  endtask

  task automatic do_reset();
    step();
    rst_i = 1'b1;
    idle_inputs();
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    logic [N-1:0] exp_order [3];
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    #1;
    check("rst_outst", 128'(outstanding_o), 128'(0));
    check("rst_err",   128'(err_o),         128'(0));
    check("rst_req",   128'(apu_req_o),     128'(0));

    // single core
    step();
    new_payload(2, 6'd5);
    core_apu_req_i = 4'b0100;
    apu_gnt_i      = 1'b1;
    #1;
    check("s1_gnt", 128'(core_apu_gnt_o), 128'(4'b0100));
    check("s1_op",  128'(apu_op_o),       128'(5));
    step();
    core_apu_req_i = '0;
    apu_rvalid_i   = 1'b1;
    apu_result_i   = 32'hDEADBEEF;
    #1;
    check("s1_rvalid", 128'(core_apu_rvalid_o), 128'(4'b0100));
    check("s1_result", 128'(core_apu_result_o), 128'(32'hDEADBEEF));
    step();
    apu_rvalid_i = 1'b0;
    #1;
    check("s1_outst", 128'(outstanding_o), 128'(0));

    // fairness
    do_reset();
    for (int c = 0; c < N; c++) new_payload(c, APU_WOP_CPU'(16 + c));
    core_apu_req_i = '1;
    apu_gnt_i      = 1'b1;
    for (int i = 0; i < 8; i++) begin
      apu_rvalid_i = (i > 0);
      #1;
      check("fair_gnt",    128'(core_apu_gnt_o), 128'(N'(1) << (i % N)));
      check("fair_onehot", 128'($countones(core_apu_gnt_o)), 128'(1));
      check("fair_op",     128'(apu_op_o), 128'(16 + (i % N)));
      step();
    end
    core_apu_req_i = '0;
    apu_rvalid_i   = 1'b1;
    step();
    apu_rvalid_i = 1'b0;
    #1;
    check("fair_drain", 128'(outstanding_o), 128'(0));

    // lock
    do_reset();
    new_payload(0, 6'd32);
    new_payload(1, 6'd33);
    new_payload(3, 6'd35);
    core_apu_req_i = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lock_op",  128'(apu_op_o),       128'(33));
      check("lock_gnt", 128'(core_apu_gnt_o), 128'(0));
      step();
    end
    core_apu_req_i = 4'b1011;
    apu_gnt_i      = 1'b1;
    #1;
    check("lock_win",  128'(core_apu_gnt_o), 128'(4'b0010));
    check("lock_op4",  128'(apu_op_o),       128'(33));
    step();
    core_apu_req_i = 4'b1001;
    #1;
    check("lock_next", 128'(core_apu_gnt_o), 128'(4'b1000));
    step();
    core_apu_req_i = 4'b0001;
    #1;
    check("lock_last", 128'(core_apu_gnt_o), 128'(4'b0001));
    step();
    idle_inputs();
    exp_order[0] = 4'b0010;
    exp_order[1] = 4'b1000;
    exp_order[2] = 4'b0001;
    apu_rvalid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lock_rsp", 128'(core_apu_rvalid_o), 128'(exp_order[i]));
      step();
    end
    apu_rvalid_i = 1'b0;

    // req dropped while locked
    do_reset();
    new_payload(1, 6'd7);
    core_apu_req_i = 4'b0010;
    step();
    core_apu_req_i = '0;
    #1;
    check("viol_hold", 128'(apu_req_o), 128'(1));
    check("viol_op",   128'(apu_op_o),  128'(7));
    step();
    apu_gnt_i = 1'b1;
    #1;
    check("viol_err", 128'(err_o),          128'(1));
    check("viol_gnt", 128'(core_apu_gnt_o), 128'(4'b0010));
    step();
    apu_gnt_i    = 1'b0;
    apu_rvalid_i = 1'b1;
    #1;
    check("viol_rsp", 128'(core_apu_rvalid_o), 128'(4'b0010));
    step();
    apu_rvalid_i = 1'b0;

    // FIFO full
    do_reset();
    for (int c = 0; c < N; c++) new_payload(c, APU_WOP_CPU'(40 + c));
    core_apu_req_i = '1;
    apu_gnt_i      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("full_fill", 128'(core_apu_gnt_o), 128'(N'(1) << i));
      step();
    end
    #1;
    check("full_outst", 128'(outstanding_o), 128'(4));
    check("full_req",   128'(apu_req_o),     128'(0));
    check("full_gnt",   128'(core_apu_gnt_o), 128'(0));
    step();
    apu_rvalid_i = 1'b1;
    #1;
    check("full_rsp",     128'(core_apu_rvalid_o), 128'(4'b0001));
    check("full_req_pop", 128'(apu_req_o),         128'(0));
    step();
    apu_rvalid_i = 1'b0;
    #1;
    check("full_outst3", 128'(outstanding_o),  128'(3));
    check("full_reissue", 128'(apu_req_o),     128'(1));
    check("full_regnt",  128'(core_apu_gnt_o), 128'(4'b0001));
    step();
    idle_inputs();
    apu_rvalid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("full_drain", 128'(core_apu_rvalid_o), 128'(N'(1) << ((i + 1) % N)));
      step();
    end
    apu_rvalid_i = 1'b0;

    // response order
    do_reset();
    apu_gnt_i = 1'b1;
    exp_order[0] = 4'b1000;
    exp_order[1] = 4'b0001;
    exp_order[2] = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      core_apu_req_i = exp_order[i];
      #1;
      check("ord_issue", 128'(core_apu_gnt_o), 128'(exp_order[i]));
      step();
    end
    idle_inputs();
    apu_rvalid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ord_rsp", 128'(core_apu_rvalid_o), 128'(exp_order[i]));
      step();
    end
    apu_rvalid_i = 1'b0;

    // spurious rvalid, then reset mid-burst
    apu_rvalid_i = 1'b1;
    #1;
    check("spur_rvalid", 128'(core_apu_rvalid_o), 128'(0));
    step();
    apu_rvalid_i = 1'b0;
    #1;
    check("spur_err", 128'(err_o), 128'(1));
    core_apu_req_i = '1;
    apu_gnt_i      = 1'b1;
    step();
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    check("mid_rst_err",   128'(err_o),          128'(0));
    check("mid_rst_outst", 128'(outstanding_o),  128'(0));
    check("mid_rst_rr",    128'(core_apu_gnt_o), 128'(4'b0001));
    step();
    idle_inputs();
    apu_rvalid_i = 1'b1;
    step();
    apu_rvalid_i = 1'b0;

    // randomized OBI-compliant traffic
    for (int cyc = 0; cyc < 1500; cyc++) begin
      step();
      for (int c = 0; c < N; c++) begin
        if (core_apu_req_i[c] && m_gnt_last[c]) begin
          if ($urandom_range(0, 1) == 1) new_payload(c, APU_WOP_CPU'($urandom));
          else core_apu_req_i[c] = 1'b0;
        end else if (!core_apu_req_i[c] && $urandom_range(0, 2) == 0) begin
          core_apu_req_i[c] = 1'b1;
          new_payload(c, APU_WOP_CPU'($urandom));
        end
      end
      apu_gnt_i    = ($urandom_range(0, 3) != 0);
      apu_rvalid_i = (exp_q.size() != 0) && ($urandom_range(0, 2) == 0);
      apu_result_i = $urandom;
      apu_flags_i  = APU_NUSFLAGS_CPU'($urandom);
    end
    step();
    idle_inputs();
    repeat (3) step();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
